// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load-unit register writes into one FIFO
// that drains one entry per cycle into a registered register-file write port.
module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [SEL_WIDTH-1:0]       alu_sel,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       ld_valid,
  input  logic [SEL_WIDTH-1:0]       ld_sel,
  input  logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       ld_ready,
  output logic                       out_write_en,
  output logic [SEL_WIDTH-1:0]       out_write_sel,
  output logic [DATA_WIDTH-1:0]      out_write_data,
  input  logic [SEL_WIDTH-1:0]       query_sel_ra,
  input  logic [SEL_WIDTH-1:0]       query_sel_rb,
  input  logic [SEL_WIDTH-1:0]       query_sel_rc,
  output logic                       pending_ra,
  output logic                       pending_rb,
  output logic                       pending_rc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_en_q, out_en_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [SEL_WIDTH-1:0]  sel_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [CW-1:0]         free;
  logic                  ld_enq, alu_enq, pop;
  logic                  wr0_en, wr1_en;
  logic [SEL_WIDTH-1:0]  wr0_sel, wr1_sel;
  logic [DATA_WIDTH-1:0] wr0_data, wr1_data;
  logic [PW-1:0]         wr0_ptr, wr1_ptr;
  logic [CW-1:0]         n_enq;
  logic [DEPTH-1:0]      entry_valid;
  logic                  hit_ra, hit_rb, hit_rc;

  // Free space is taken from the registered count, so a pop this cycle never frees a slot early.
  assign free      = CW'(DEPTH) - count_q;
  assign ld_ready  = rst_n & (free != '0);
  assign alu_ready = rst_n & ((free >= CW'(2)) | ((free != '0) & ~ld_valid));

  assign ld_enq  = ld_valid  & ld_ready  & (ld_sel  != '0);
  assign alu_enq = alu_valid & alu_ready & (alu_sel != '0);
  assign pop     = (count_q != '0);

  always_comb begin
    wr0_en   = 1'b0;
    wr0_sel  = ld_sel;
    wr0_data = ld_data;
    wr1_en   = 1'b0;
    wr1_sel  = alu_sel;
    wr1_data = alu_data;
    if (ld_enq) begin
      wr0_en = 1'b1;
      wr1_en = alu_enq;
    end else if (alu_enq) begin
      wr0_en   = 1'b1;
      wr0_sel  = alu_sel;
      wr0_data = alu_data;
    end
  end

  assign wr0_ptr = tail_q;
  assign wr1_ptr = tail_q + PW'(1);
  assign n_enq   = CW'(wr0_en) + CW'(wr1_en);

  always_comb begin
    count_d    = count_q + n_enq - CW'(pop);
    tail_d     = tail_q + PW'(n_enq);
    head_d     = head_q + PW'(pop);
    out_en_d   = pop;
    out_sel_d  = out_sel_q;
    out_data_d = out_data_q;
    if (pop) begin
      out_sel_d  = sel_mem[head_q];
      out_data_d = data_mem[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_en_q   <= 1'b0;
      out_sel_q  <= '0;
      out_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_en_q   <= out_en_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage is not reset; only entries inside the head/count window are meaningful.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      sel_mem[wr0_ptr]  <= wr0_sel;
      data_mem[wr0_ptr] <= wr0_data;
    end
    if (wr1_en) begin
      sel_mem[wr1_ptr]  <= wr1_sel;
      data_mem[wr1_ptr] <= wr1_data;
    end
  end

  always_comb begin
    entry_valid = '0;
    hit_ra      = 1'b0;
    hit_rb      = 1'b0;
    hit_rc      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset         = PW'(i) - head_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
      if (entry_valid[i] && sel_mem[i] == query_sel_ra) hit_ra = 1'b1;
      if (entry_valid[i] && sel_mem[i] == query_sel_rb) hit_rb = 1'b1;
      if (entry_valid[i] && sel_mem[i] == query_sel_rc) hit_rc = 1'b1;
    end
  end

  assign pending_ra = (query_sel_ra != '0) &
                      (hit_ra | (out_en_q & (out_sel_q == query_sel_ra)));
  assign pending_rb = (query_sel_rb != '0) &
                      (hit_rb | (out_en_q & (out_sel_q == query_sel_rb)));
  assign pending_rc = (query_sel_rc != '0) &
                      (hit_rc | (out_en_q & (out_sel_q == query_sel_rc)));

  assign out_write_en   = out_en_q;
  assign out_write_sel  = out_sel_q;
  assign out_write_data = out_data_q;
  assign count          = count_q;
  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: accepted writes are queued as they
// are driven and compared in order as the register-file port emits them.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk;
  logic          rst_n;
  logic          alu_valid, ld_valid;
  logic [SW-1:0] alu_sel, ld_sel;
  logic [DW-1:0] alu_data, ld_data;
  logic          alu_ready, ld_ready;
  logic          out_write_en;
  logic [SW-1:0] out_write_sel;
  logic [DW-1:0] out_write_data;
  logic [SW-1:0] query_sel_ra, query_sel_rb, query_sel_rc;
  logic          pending_ra, pending_rb, pending_rc;
  logic [CW-1:0] count;
  logic          full, empty;

  entry_t        sb[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            model_count  = 0;
  bit            exp_en       = 1'b0;
  logic [SW-1:0] last_sel     = '0;

  writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data), .ld_ready(ld_ready),
    .out_write_en(out_write_en), .out_write_sel(out_write_sel), .out_write_data(out_write_data),
    .query_sel_ra(query_sel_ra), .query_sel_rb(query_sel_rb), .query_sel_rc(query_sel_rc),
    .pending_ra(pending_ra), .pending_rb(pending_rb), .pending_rc(pending_rc),
    .count(count), .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // A register is pending if a queued entry or the live output targets it.
  function automatic bit expPending(input logic [SW-1:0] q);
    if (q == '0) return 1'b0;
    foreach (sb[i]) if (sb[i].sel == q) return 1'b1;
    return exp_en && (last_sel == q);
  endfunction

  // Output port monitor: every emitted write must match the oldest accepted entry.
  always @(negedge clk) begin
    entry_t e;
    checkOutput("out_en", out_write_en, exp_en);
    if (out_write_en && exp_en && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("out_sel", out_write_sel, e.sel);
      checkOutput("out_data", out_write_data, e.data);
      last_sel = e.sel;
    end
  end

  // Drives one cycle of requests (called just after a rising edge) and advances the model.
  task automatic applyStimulus(input bit lv, input logic [SW-1:0] ls, input logic [DW-1:0] ldd,
                               input bit av, input logic [SW-1:0] as, input logic [DW-1:0] ad);
    int free;
    int n;
    bit er_ld, er_alu;
    ld_valid  = lv;
    ld_sel    = ls;
    ld_data   = ldd;
    alu_valid = av;
    alu_sel   = as;
    alu_data  = ad;
    @(negedge clk);
    #1;
    free   = DEPTH - model_count;
    er_ld  = (free >= 1);
    er_alu = (free >= 2) || (free >= 1 && !lv);
    checkOutput("ld_ready", ld_ready, er_ld);
    checkOutput("alu_ready", alu_ready, er_alu);
    checkOutput("count", count, model_count);
    checkOutput("full", full, model_count == DEPTH);
    checkOutput("empty", empty, model_count == 0);
    checkOutput("pending_ra", pending_ra, expPending(query_sel_ra));
    checkOutput("pending_rb", pending_rb, expPending(query_sel_rb));
    checkOutput("pending_rc", pending_rc, expPending(query_sel_rc));
    n = 0;
    if (lv && er_ld && ls != '0) begin
      sb.push_back(entry_t'{sel: ls, data: ldd});
      n++;
    end
    if (av && er_alu && as != '0) begin
      sb.push_back(entry_t'{sel: as, data: ad});
      n++;
    end
    @(posedge clk);
    exp_en      = (model_count > 0);
    model_count = model_count + n - (exp_en ? 1 : 0);
    #1;
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    model_count = 0;
    exp_en      = 1'b0;
    sb.delete();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_out_en", out_write_en, 0);
    checkOutput("rst_out_sel", out_write_sel, 0);
    checkOutput("rst_out_data", out_write_data, 0);
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_pending_ra", pending_ra, 0);
    checkOutput("rst_pending_rb", pending_rb, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    ld_valid     = 1'b0;
    alu_valid    = 1'b0;
    ld_sel       = '0;
    alu_sel      = '0;
    ld_data      = '0;
    alu_data     = '0;
    query_sel_ra = 4'd3;
    query_sel_rb = 4'd5;
    query_sel_rc = 4'd0;
    @(posedge clk);
    #1;
    applyReset();

    // Single ALU write and its pending window
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF);
    checkOutput("single_pend_e1", pending_ra, 1);
    idleCycle();
    checkOutput("single_en", out_write_en, 1);
    checkOutput("single_sel", out_write_sel, 4'd3);
    checkOutput("single_data", out_write_data, 32'hDEADBEEF);
    checkOutput("single_pend_e2", pending_ra, 1);
    idleCycle();
    checkOutput("single_pend_e3", pending_ra, 0);
    idleCycle();

    // Dual accept into an empty queue
    query_sel_rc = 4'd6;
    applyStimulus(1'b1, 4'd5, 32'h11, 1'b1, 4'd6, 32'h22);
    idleCycle();
    checkOutput("dual_first_sel", out_write_sel, 4'd5);
    idleCycle();
    checkOutput("dual_second_sel", out_write_sel, 4'd6);
    idleCycle();
    idleCycle();

    // Back-to-back dual pushes until the one-free-slot case stalls the ALU
    query_sel_ra = 4'd7;
    query_sel_rb = 4'd8;
    query_sel_rc = 4'd1;
    applyStimulus(1'b1, 4'd1, 32'hA001, 1'b1, 4'd2, 32'hA002);
    applyStimulus(1'b1, 4'd3, 32'hA003, 1'b1, 4'd4, 32'hA004);
    checkOutput("fill_count3", count, 3);
    applyStimulus(1'b1, 4'd5, 32'hA005, 1'b1, 4'd6, 32'hA006);
    applyStimulus(1'b1, 4'd7, 32'hA007, 1'b1, 4'd8, 32'hA008);
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd9, 32'hA009);
    for (int i = 0; i < 6; i++) idleCycle();
    checkOutput("drain_empty", empty, 1);

    // Writes to the zero register are consumed but never queued
    query_sel_ra = 4'd0;
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd0, 32'hBAD0);
    checkOutput("zero_count", count, 0);
    applyStimulus(1'b1, 4'd0, 32'hBAD1, 1'b1, 4'd0, 32'hBAD2);
    idleCycle();
    idleCycle();

    // Reset in the middle of a stream drops everything queued
    query_sel_ra = 4'd10;
    query_sel_rb = 4'd11;
    applyStimulus(1'b1, 4'd10, 32'hB010, 1'b1, 4'd11, 32'hB011);
    applyStimulus(1'b1, 4'd12, 32'hB012, 1'b1, 4'd13, 32'hB013);
    checkOutput("pre_reset_count", count, 3);
    applyReset();
    for (int i = 0; i < 4; i++) idleCycle();

    // Random traffic with random hazard queries
    for (int i = 0; i < 300; i++) begin
      query_sel_ra = 4'($urandom_range(0, 15));
      query_sel_rb = 4'($urandom_range(0, 15));
      query_sel_rc = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
    end
    for (int i = 0; i < 8; i++) idleCycle();
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
